alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Upstream command buffer and sequencer for the 8-bit logical unit. It accepts {opcode, a, b} commands over a valid/ready interface and queues them in a small FIFO. It issues one command at a time on registered opcode/a/b lines to the logical unit, waits out that unit's 1-cycle registered latency, then captures its output. The captured result is returned with the opcode tag on a valid/ready result interface.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
AW, 2, FIFO pointer width, log2(DEPTH)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (count < DEPTH)
cmd_opcode  in  4  operation code
cmd_a  in  8  operand A
cmd_b  in  8  operand B
alu_opcode  out  4  registered opcode to logical unit
alu_a  out  8  registered operand A to logical unit
alu_b  out  8  registered operand B to logical unit
alu_out  in  8  registered result from logical unit
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  8  captured result
res_opcode  out  4  opcode that produced res_data
res_err  out  1  opcode outside 4'b0101..4'b1110 (result is 0)
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. At reset, state is IDLE and FIFO rd_ptr, wr_ptr and count are 0. alu_opcode, alu_a, alu_b, res_data, res_opcode and res_err are 0. res_valid is 0. cmd_ready is 1 after the reset edge. rst mid-operation discards queued commands, any in-flight command and any held result.
- FIFO push and pop:
  - Push occurs when cmd_valid && cmd_ready.
  - Pop occurs when the FSM issues.
  - Push and pop in the same cycle leave count unchanged.
  - When full, cmd_ready is 0 and nothing is written.
  - An entry pushed into an empty FIFO is not popped in the same cycle; the earliest issue is the next edge.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC1, EXEC2, DONE.
  - IDLE: if count != 0, load the FIFO head into alu_opcode/a/b, pop, and go to EXEC1. Otherwise stay; alu_opcode is held at 4'b0000.
  - EXEC1: the logical unit samples. Go to EXEC2 unconditionally.
  - EXEC2: res_data <= alu_out, res_opcode <= alu_opcode, res_err set from the opcode range, res_valid <= 1. Go to DONE.
  - DONE: hold res_* stable while res_valid && !res_ready. On handshake, res_valid <= 0.
    - If count != 0 on that same edge, issue the next head (back-to-back) and go to EXEC1.
    - Otherwise alu_opcode <= 0 and go to IDLE.
- Latency: command accepted at edge T gives res_valid high after edge T+3. Throughput with res_ready held 1 is one result per 3 cycles.
- Ordering: results are returned strictly in command order. No command is dropped or duplicated under any res_ready pattern.
- Operands are passed unmodified; this block performs no arithmetic.

Decomposition:
- Shared include alu_defs.vh holds:
  - opcode constants OP_OR=4'b0101, OP_AND=4'b0110, OP_NOT=4'b0111, OP_XOR=4'b1000, OP_XNOR=4'b1001, OP_NAND=4'b1010, OP_NOR=4'b1011, OP_SHL=4'b1100, OP_SAR=4'b1101, OP_INC=4'b1110;
  - the valid-range bounds;
  - the FSM state encodings.
- One sub-module, alu_cmd_fifo: a parameterised synchronous FIFO with 20-bit entries, push/pop/full/empty/count. The FSM and result register stay in alu_issue_ctrl.

Test Plan:
- Reset then single OR: push {0101, 0x0F, 0xF0} at edge T → res_valid rises after T+3, res_data=0xFF, res_opcode=0101, res_err=0.
- Burst of 4 with res_ready=1: AND 0xCC/0xAA, SHL 0x81, SAR 0x81, INC 0xFF → in order 0x88, 0x02, 0xC0, 0x00; results spaced 3 cycles apart.
- Full FIFO: hold res_ready=0 and push 6 commands → cmd_ready drops after 4 queued + 1 in flight. No result changes while stalled; raising res_ready drains all 5 in order.
- Invalid opcode 4'b0011 with a=0x55 → res_data=0x00, res_err=1, res_opcode=0011.
- Simultaneous push and pop at count=1 → count stays 1 and the FIFO head is correct for the next issue.
- rst asserted during EXEC1 with 3 queued → next cycle res_valid=0, busy=0, cmd_ready=1, all alu_* outputs 0, and no stale result appears afterwards.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: opcodes, valid opcode range, FSM states and command layout
package alu_issue_ctrl_pkg;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SAR  = 4'b1101;
    localparam logic [3:0] OP_INC  = 4'b1110;
    localparam logic [3:0] OP_MIN  = OP_OR;
    localparam logic [3:0] OP_MAX  = OP_INC;

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    function automatic logic op_err(input logic [3:0] op);
        return op < OP_MIN || op > OP_MAX;
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO, power-of-2 depth, push ignored when full, pop ignored when empty
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q[AW];
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues logical-unit commands, issues them one at a time and returns tagged results
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_opcode,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_opcode,
    output logic       res_err,
    output logic       busy
);
    state_e      state_q, state_d;
    cmd_t        head;
    logic        full, empty, pop;
    logic [AW:0] count;
    logic        can_issue, issue, capture;
    logic [3:0]  alu_opcode_q, alu_opcode_d, res_opcode_q, res_opcode_d;
    logic [7:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
    logic        res_valid_q, res_valid_d, res_err_q, res_err_d;

    alu_cmd_fifo #(.DEPTH(DEPTH), .AW(AW), .W($bits(cmd_t))) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .din_i   ({cmd_opcode, cmd_a, cmd_b}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // DONE with a handshake behaves like IDLE so the next command issues back-to-back
    assign can_issue = state_q == IDLE || (state_q == DONE && res_ready);
    assign issue     = can_issue && count != '0;
    assign capture   = state_q == EXEC2;
    assign pop       = issue;

    always_comb begin
        state_d      = issue ? EXEC1 : can_issue ? IDLE : state_q == EXEC1 ? EXEC2 :
                       state_q == EXEC2 ? DONE : state_q;
        alu_opcode_d = issue ? head.opcode : can_issue ? 4'b0000 : alu_opcode_q;
        alu_a_d      = issue ? head.a : alu_a_q;
        alu_b_d      = issue ? head.b : alu_b_q;
        res_valid_d  = capture ? 1'b1 : (state_q == DONE && res_ready) ? 1'b0 : res_valid_q;
        res_data_d   = capture ? alu_out : res_data_q;
        res_opcode_d = capture ? alu_opcode_q : res_opcode_q;
        res_err_d    = capture ? op_err(alu_opcode_q) : res_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_opcode_q <= '0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_opcode_q <= res_opcode_d;
            res_err_q    <= res_err_d;
        end
    end

    assign cmd_ready  = !full;
    assign busy       = state_q != IDLE || !empty;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_opcode = res_opcode_q;
    assign res_err    = res_err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors plus multi-cycle sequences against a registered logical-unit model
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_opcode = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_out = 8'h00;
    logic       res_valid, res_ready = 1'b0, res_err, busy;
    logic [7:0] res_data;
    logic [3:0] res_opcode;

    int n_checks = 0;
    int n_err = 0;

    alu_issue_ctrl #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_opcode(res_opcode), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h5: return a | b;
            4'h6: return a & b;
            4'h7: return ~a;
            4'h8: return a ^ b;
            4'h9: return ~(a ^ b);
            4'hA: return ~(a & b);
            4'hB: return ~(a | b);
            4'hC: return {a[6:0], 1'b0};
            4'hD: return {a[7], a[7:1]};
            4'hE: return a + 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) alu_out <= lu(alu_opcode, alu_a, alu_b);

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        logic       err;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int k = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        while (!cmd_ready && k < 20) begin tick(); k++; end
        if (!cmd_ready) chk("push_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int k = 0;
        while (!res_valid && k < 20) begin tick(); k++; end
        if (!res_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [7:0] got_d[$];
        int         got_c[$];
        logic [3:0] fop[6], bop[4];
        logic [7:0] fa[6], fb[6], fexp[5], ba[4], bb[4], bexp[4];
        logic       rdy;
        int         n, seen;

        tbl[0]  = '{4'h5, 8'h0F, 8'hF0, 8'hFF, 1'b0};
        tbl[1]  = '{4'h6, 8'hCC, 8'hAA, 8'h88, 1'b0};
        tbl[2]  = '{4'h7, 8'h3C, 8'h00, 8'hC3, 1'b0};
        tbl[3]  = '{4'h8, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        tbl[4]  = '{4'h9, 8'hF0, 8'h3C, 8'h33, 1'b0};
        tbl[5]  = '{4'hA, 8'hCC, 8'hAA, 8'h77, 1'b0};
        tbl[6]  = '{4'hB, 8'hCC, 8'hAA, 8'h11, 1'b0};
        tbl[7]  = '{4'hC, 8'h81, 8'h00, 8'h02, 1'b0};
        tbl[8]  = '{4'hD, 8'h81, 8'h00, 8'hC0, 1'b0};
        tbl[9]  = '{4'hD, 8'h40, 8'h00, 8'h20, 1'b0};
        tbl[10] = '{4'hE, 8'hFF, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{4'hE, 8'h7F, 8'h00, 8'h80, 1'b0};
        tbl[12] = '{4'h3, 8'h55, 8'h00, 8'h00, 1'b1};
        tbl[13] = '{4'h4, 8'hFF, 8'hFF, 8'h00, 1'b1};
        tbl[14] = '{4'hF, 8'hFF, 8'hFF, 8'h00, 1'b1};
        bop = '{4'h6, 4'hC, 4'hD, 4'hE};
        ba  = '{8'hCC, 8'h81, 8'h81, 8'hFF};
        bb  = '{8'hAA, 8'h00, 8'h00, 8'h00};
        bexp = '{8'h88, 8'h02, 8'hC0, 8'h00};
        fop = '{4'h5, 4'h6, 4'h8, 4'hE, 4'h7, 4'hC};
        fa  = '{8'h01, 8'hF0, 8'hFF, 8'h10, 8'h00, 8'h01};
        fb  = '{8'h02, 8'h3C, 8'h0F, 8'h00, 8'h00, 8'h00};
        fexp = '{8'h03, 8'h30, 8'hF0, 8'h11, 8'hFF};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
        chk("rst_res", {res_data, res_opcode, res_err}, 0);

        // Single OR with latency check, result held while res_ready is low
        push(4'h5, 8'h0F, 8'hF0);
        chk("lat_t0", res_valid, 0);
        tick(); chk("lat_t1", res_valid, 0);
        tick(); chk("lat_t2", res_valid, 0);
        tick(); chk("lat_t3", res_valid, 1);
        chk("or_data", res_data, 8'hFF);
        chk("or_op", res_opcode, 4'h5);
        chk("or_err", res_err, 0);
        tick(); chk("or_hold", {res_valid, res_data}, {1'b1, 8'hFF});
        res_ready = 1'b1;
        tick(); chk("or_consumed", res_valid, 0);
        tick(); chk("idle_alu_op", alu_opcode, 0);

        // Table-driven single commands
        for (int i = 0; i < 15; i++) begin
            push(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_res($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_data", i), res_data, tbl[i].exp);
            chk($sformatf("vec%0d_op", i), res_opcode, tbl[i].op);
            chk($sformatf("vec%0d_err", i), res_err, tbl[i].err);
            tick();
        end
        tick(); tick();

        // Burst of 4 with res_ready held high: one result every 3 cycles
        for (int c = 0; c < 20; c++) begin
            cmd_valid = c < 4;
            if (c < 4) begin cmd_opcode = bop[c]; cmd_a = ba[c]; cmd_b = bb[c]; end
            tick();
            if (res_valid) begin got_d.push_back(res_data); got_c.push_back(c); end
        end
        cmd_valid = 1'b0;
        chk("burst_count", got_d.size(), 4);
        if (got_c.size() > 0) chk("burst_first_lat", got_c[0], 3);
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            chk($sformatf("burst%0d_data", i), got_d[i], bexp[i]);
            if (i > 0) chk($sformatf("burst%0d_gap", i), got_c[i] - got_c[i-1], 3);
        end

        // Full FIFO with result stalled
        res_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = n < 6;
            if (n < 6) begin cmd_opcode = fop[n]; cmd_a = fa[n]; cmd_b = fb[n]; end
            rdy = cmd_ready;
            tick();
            if (cmd_valid && rdy) n++;
        end
        cmd_valid = 1'b0;
        chk("full_accepted", n, 5);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_stall_valid", res_valid, 1);
        chk("full_stall_data", res_data, 8'h03);
        tick(); tick(); tick();
        chk("full_stall_hold", {res_valid, res_opcode, res_data}, {1'b1, 4'h5, 8'h03});
        got_d.delete();
        res_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (res_valid) got_d.push_back(res_data);
            tick();
        end
        chk("drain_count", got_d.size(), 5);
        for (int i = 0; i < got_d.size() && i < 5; i++)
            chk($sformatf("drain%0d_data", i), got_d[i], fexp[i]);
        chk("drain_busy", busy, 0);

        // Simultaneous push and pop at count=1
        res_ready = 1'b0;
        push(4'h8, 8'hA5, 8'hFF);
        push(4'h6, 8'h3C, 8'h0F);
        wait_res("pp_x");
        chk("pp_x_data", res_data, 8'h5A);
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_opcode = 4'h5; cmd_a = 8'h11; cmd_b = 8'h22;
        tick();
        cmd_valid = 1'b0;
        chk("pp_issue_head", {alu_opcode, alu_a, alu_b}, {4'h6, 8'h3C, 8'h0F});
        chk("pp_busy", busy, 1);
        wait_res("pp_y");
        chk("pp_y_data", res_data, 8'h0C);
        tick();
        wait_res("pp_z");
        chk("pp_z_data", {res_opcode, res_data}, {4'h5, 8'h33});
        tick(); tick();

        // Reset during EXEC1 with 3 commands queued
        res_ready = 1'b0;
        push(4'h5, 8'h01, 8'h00);
        push(4'h6, 8'hFF, 8'h0F);
        push(4'h7, 8'h0F, 8'h00);
        push(4'h8, 8'hFF, 8'h01);
        push(4'hE, 8'h41, 8'h00);
        wait_res("rst_a");
        res_ready = 1'b1;
        tick();
        chk("rst_exec1_head", {alu_opcode, alu_a}, {4'h6, 8'hFF});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_alu", {alu_opcode, alu_a, alu_b}, 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (res_valid) seen++;
        end
        chk("no_stale_result", seen, 0);
        push(4'hB, 8'h0F, 8'h30);
        wait_res("post_rst");
        chk("post_rst_data", {res_opcode, res_data, res_err}, {4'hB, 8'hC0, 1'b0});
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
